sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter PAT_W, default 6, meaning pattern length in bits (range 2..16).
REQ-002 SHALL have parameter PATTERN, default 6'b101110, meaning the bit pattern, sent MSB first.
REQ-003 SHALL have parameter GAP, default 1, meaning idle cycles between repeated patterns (0..15).
REQ-004 SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, request to begin a transmission burst.
REQ-007 SHALL have port repeat_cnt, input, 4 bits, number of patterns in the burst, sampled with start.
REQ-008 SHALL have port abort, input, 1 bit, terminates the burst.
REQ-009 SHALL have port out, output, 1 bit, serial data bit.
REQ-010 SHALL have port valid, output, 1 bit, out carries a pattern bit this cycle.
REQ-011 SHALL have port busy, output, 1 bit, burst in progress.
REQ-012 SHALL have port done, output, 1 bit, one-cycle burst-complete pulse.
REQ-013 SHALL have port sent_count, output, 8 bits, number of completed patterns since reset, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP, DONE; all outputs registered.
REQ-015 IDLE: start=1 and abort=0 SHALL latch repeat_cnt, load PATTERN into the shift register, and go to SHIFT (or DONE if repeat_cnt=0).
REQ-016 First pattern bit SHALL appear on out with valid=1 in the cycle after start is sampled (latency 1).
REQ-017 SHIFT: one bit per cycle, MSB first, valid=1, busy=1, for exactly PAT_W cycles.
REQ-018 After the last bit of a pattern, sent_count SHALL increment by 1 and saturate at 255.
REQ-019 After the last bit, if patterns remain and GAP>0, go to GAP; if GAP=0, reload and continue SHIFT back-to-back; if none remain, go to DONE.
REQ-020 GAP: out=0, valid=0, busy=1 for exactly GAP cycles; then reload PATTERN and go to SHIFT.
REQ-021 DONE: done=1, busy=1, valid=0 for exactly one cycle, then IDLE.
REQ-022 In IDLE, out=0, valid=0, busy=0, done=0.
REQ-023 start SHALL be ignored outside IDLE; no queuing.
REQ-024 abort=1 in SHIFT, GAP or DONE SHALL return the FSM to IDLE on the next edge with out=0 and valid=0; there SHALL be no done pulse and no sent_count increment for the partial pattern.
REQ-025 abort and start both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 repeat_cnt=0 with start SHALL give DONE (done pulse) on the next cycle, with valid never asserted.
REQ-027 The remaining-pattern counter SHALL be 4 bits and the bit index SHALL be ceil(log2(PAT_W)) bits; neither SHALL wrap within a burst.

Reset
REQ-028 rst low SHALL immediately force state=IDLE, out=0, valid=0, busy=0, done=0, sent_count=0, shift register=0 and all counters=0, independent of clk.
REQ-029 Reset asserted mid-burst SHALL discard the burst; after release, the block SHALL wait for a new start.
REQ-030 The first start SHALL be accepted on the first rising edge after rst goes high.

Structure
REQ-031 Shared package seq_pkg SHALL hold the state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the default pattern constant 6'b101110.
REQ-032 Sub-module seq_shift_reg (PAT_W-bit parallel-load, shift-left, MSB-out register with load/shift enables) SHALL be used; FSM and counters SHALL stay in sequence_generator.

Verification
REQ-033 Defaults, repeat_cnt=1, start pulse at cycle 0 -> out=1,0,1,1,1,0 with valid=1 on cycles 1-6; done=1 on cycle 7; sent_count=1; busy=0 from cycle 8.
REQ-034 repeat_cnt=2, GAP=2 -> 6 valid bits, 2 cycles valid=0/out=0, 6 valid bits, then done; sent_count increases by 2.
REQ-035 repeat_cnt=0 -> done pulse on cycle 1, valid stays 0, sent_count unchanged.
REQ-036 abort during the 4th bit of the first pattern -> next cycle IDLE, no done, sent_count unchanged; start during a burst has no effect.
REQ-037 rst low mid-burst, between clock edges -> outputs and sent_count are 0 before the next edge; a fresh start after release gives the full 101110.
REQ-038 Back-to-back bursts totalling 260 patterns -> sent_count holds at 255.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern sequence generator.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [5:0] DEFAULT_PATTERN = 6'b101110;
  localparam logic [7:0] SENT_MAX        = 8'hFF;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB as the serial bit.
module seq_shift_reg #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial burst generator: sends PATTERN (MSB first) repeat_cnt times,
// separated by GAP idle cycles, with a one-cycle done pulse at the end.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int unsigned      GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] repeat_cnt,
  input  logic       abort,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_count
);

  localparam int unsigned      IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit               HAS_GAP  = (GAP > 0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [3:0]       rem_q, rem_d;
  logic [3:0]       gap_q, gap_d;
  logic             valid_d, busy_d, done_d;
  logic             cnt_inc;
  logic             sr_load, sr_shift;
  logic [PAT_W-1:0] sr_din;

  // out is the register MSB directly; after PAT_W shifts the register is
  // all zeros, so out reads 0 in GAP/DONE/IDLE without extra gating.
  seq_shift_reg #(
    .W (PAT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_inc  = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = PATTERN;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rem_d  = repeat_cnt;
          bit_d  = '0;
          busy_d = 1'b1;
          if (repeat_cnt == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
            sr_load = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          bit_d   = '0;
          sr_load = 1'b1;
          sr_din  = '0;
        end else if (bit_q != IDX_LAST) begin
          bit_d    = bit_q + IDX_W'(1);
          sr_shift = 1'b1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          rem_d   = rem_q - 4'd1;
          bit_d   = '0;
          busy_d  = 1'b1;
          if (rem_q == 4'd1) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            sr_shift = 1'b1;
          end else if (HAS_GAP) begin
            state_d  = S_GAP;
            gap_d    = '0;
            sr_shift = 1'b1;
          end else begin
            sr_load = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          busy_d = 1'b1;
          if (gap_q == GAP_LAST) begin
            state_d = S_SHIFT;
            gap_d   = '0;
            sr_load = 1'b1;
            valid_d = 1'b1;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
    end else begin
      bit_q <= bit_d;
      rem_q <= rem_d;
      gap_q <= gap_d;
      valid <= valid_d;
      busy  <= busy_d;
      done  <= done_d;
      if (cnt_inc && (sent_count != SENT_MAX)) begin
        sent_count <= sent_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator (three parameterisations).
module tb_sequence_generator;

  logic clk;
  logic rst;

  logic       d_start, d_abort, d_out, d_valid, d_busy, d_done;
  logic [3:0] d_rc;
  logic [7:0] d_cnt;

  logic       g2_start, g2_abort, g2_out, g2_valid, g2_busy, g2_done;
  logic [3:0] g2_rc;
  logic [7:0] g2_cnt;

  logic       g0_start, g0_abort, g0_out, g0_valid, g0_busy, g0_done;
  logic [3:0] g0_rc;
  logic [7:0] g0_cnt;

  int tests;
  int fails;

  sequence_generator u_dut (
    .clk(clk), .rst(rst), .start(d_start), .repeat_cnt(d_rc), .abort(d_abort),
    .out(d_out), .valid(d_valid), .busy(d_busy), .done(d_done), .sent_count(d_cnt)
  );

  sequence_generator #(
    .GAP (2)
  ) u_g2 (
    .clk(clk), .rst(rst), .start(g2_start), .repeat_cnt(g2_rc), .abort(g2_abort),
    .out(g2_out), .valid(g2_valid), .busy(g2_busy), .done(g2_done), .sent_count(g2_cnt)
  );

  sequence_generator #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .GAP     (0)
  ) u_g0 (
    .clk(clk), .rst(rst), .start(g0_start), .repeat_cnt(g0_rc), .abort(g0_abort),
    .out(g0_out), .valid(g0_valid), .busy(g0_busy), .done(g0_done), .sent_count(g0_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (d_out !== 1'b0 || d_valid !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_dut: out=%b valid=%b busy=%b done=%b cnt=%0d, want all 0",
               d_out, d_valid, d_busy, d_done, d_cnt);
    end
    tests++;
    if (g2_cnt !== 8'd0 || g0_cnt !== 8'd0 || g2_busy !== 1'b0 || g0_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_others: g2_cnt=%0d g0_cnt=%0d g2_busy=%b g0_valid=%b, want 0",
               g2_cnt, g0_cnt, g2_busy, g0_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_full_pattern(input string name, input logic [7:0] want_cnt);
    logic [5:0] pat;
    pat = 6'b101110;
    d_rc    = 4'd1;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (d_out !== pat[5-i] || d_valid !== 1'b1 || d_busy !== 1'b1 || d_done !== 1'b0) begin
        fails++;
        $display("FAIL %s_bit%0d: out=%b valid=%b busy=%b done=%b, want out=%b valid=1 busy=1 done=0",
                 name, i, d_out, d_valid, d_busy, d_done, pat[5-i]);
      end
      tick();
    end
    tests++;
    if (d_done !== 1'b1 || d_valid !== 1'b0 || d_busy !== 1'b1 || d_out !== 1'b0 || d_cnt !== want_cnt) begin
      fails++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b out=%b cnt=%0d, want done=1 valid=0 busy=1 out=0 cnt=%0d",
               name, d_done, d_valid, d_busy, d_out, d_cnt, want_cnt);
    end
    tick();
    tests++;
    if (d_busy !== 1'b0 || d_done !== 1'b0 || d_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b done=%b valid=%b, want 0 0 0", name, d_busy, d_done, d_valid);
    end
  endtask

  task automatic test_single;
    run_full_pattern("single", 8'd1);
  endtask

  task automatic test_zero_repeat;
    d_rc    = 4'd0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tests++;
    if (d_done !== 1'b1 || d_valid !== 1'b0 || d_busy !== 1'b1 || d_out !== 1'b0 || d_cnt !== 8'd1) begin
      fails++;
      $display("FAIL zero_done: done=%b valid=%b busy=%b out=%b cnt=%0d, want 1 0 1 0 cnt=1",
               d_done, d_valid, d_busy, d_out, d_cnt);
    end
    tick();
    tests++;
    if (d_done !== 1'b0 || d_valid !== 1'b0 || d_busy !== 1'b0 || d_cnt !== 8'd1) begin
      fails++;
      $display("FAIL zero_after: done=%b valid=%b busy=%b cnt=%0d, want 0 0 0 cnt=1",
               d_done, d_valid, d_busy, d_cnt);
    end
  endtask

  task automatic test_abort;
    d_rc    = 4'd3;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    d_start = 1'b1;
    d_rc    = 4'd1;
    tick();
    d_start = 1'b0;
    tick();
    tests++;
    if (d_out !== 1'b1 || d_valid !== 1'b1 || d_busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_4th_bit: out=%b valid=%b busy=%b, want 1 1 1", d_out, d_valid, d_busy);
    end
    d_abort = 1'b1;
    tick();
    d_abort = 1'b0;
    tests++;
    if (d_out !== 1'b0 || d_valid !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_cnt !== 8'd1) begin
      fails++;
      $display("FAIL abort_idle: out=%b valid=%b busy=%b done=%b cnt=%0d, want 0 0 0 0 cnt=1",
               d_out, d_valid, d_busy, d_done, d_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (d_busy !== 1'b0 || d_done !== 1'b0 || d_valid !== 1'b0 || d_cnt !== 8'd1) begin
        fails++;
        $display("FAIL abort_stay%0d: busy=%b done=%b valid=%b cnt=%0d, want 0 0 0 cnt=1",
                 i, d_busy, d_done, d_valid, d_cnt);
      end
    end
    d_start = 1'b1;
    d_abort = 1'b1;
    d_rc    = 4'd1;
    tick();
    d_start = 1'b0;
    d_abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (d_busy !== 1'b0 || d_valid !== 1'b0 || d_done !== 1'b0) begin
        fails++;
        $display("FAIL abort_wins%0d: busy=%b valid=%b done=%b, want 0 0 0", i, d_busy, d_valid, d_done);
      end
      tick();
    end
  endtask

  task automatic test_gap2;
    logic [5:0] pat;
    pat = 6'b101110;
    g2_rc    = 4'd2;
    g2_start = 1'b1;
    tick();
    g2_start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (g2_out !== pat[5-i] || g2_valid !== 1'b1 || g2_busy !== 1'b1) begin
          fails++;
          $display("FAIL gap2_p%0d_bit%0d: out=%b valid=%b busy=%b, want out=%b valid=1 busy=1",
                   p, i, g2_out, g2_valid, g2_busy, pat[5-i]);
        end
        tick();
      end
      if (p == 0) begin
        for (int g = 0; g < 2; g++) begin
          tests++;
          if (g2_out !== 1'b0 || g2_valid !== 1'b0 || g2_busy !== 1'b1 || g2_done !== 1'b0) begin
            fails++;
            $display("FAIL gap2_gap%0d: out=%b valid=%b busy=%b done=%b, want 0 0 1 0",
                     g, g2_out, g2_valid, g2_busy, g2_done);
          end
          tick();
        end
      end
    end
    tests++;
    if (g2_done !== 1'b1 || g2_valid !== 1'b0 || g2_cnt !== 8'd2) begin
      fails++;
      $display("FAIL gap2_done: done=%b valid=%b cnt=%0d, want done=1 valid=0 cnt=2", g2_done, g2_valid, g2_cnt);
    end
    tick();
    tests++;
    if (g2_busy !== 1'b0 || g2_done !== 1'b0) begin
      fails++;
      $display("FAIL gap2_idle: busy=%b done=%b, want 0 0", g2_busy, g2_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    pat = 4'b1011;
    g0_rc    = 4'd3;
    g0_start = 1'b1;
    tick();
    g0_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (g0_out !== pat[3-(i%4)] || g0_valid !== 1'b1 || g0_busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_bit%0d: out=%b valid=%b busy=%b, want out=%b valid=1 busy=1",
                 i, g0_out, g0_valid, g0_busy, pat[3-(i%4)]);
      end
      if (i == 4) begin
        tests++;
        if (g0_cnt !== 8'd1) begin
          fails++;
          $display("FAIL b2b_cnt_mid: cnt=%0d, want 1", g0_cnt);
        end
      end
      tick();
    end
    tests++;
    if (g0_done !== 1'b1 || g0_valid !== 1'b0 || g0_out !== 1'b0 || g0_cnt !== 8'd3) begin
      fails++;
      $display("FAIL b2b_done: done=%b valid=%b out=%b cnt=%0d, want 1 0 0 cnt=3",
               g0_done, g0_valid, g0_out, g0_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    d_rc    = 4'd2;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (d_out !== 1'b0 || d_valid !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_async: out=%b valid=%b busy=%b done=%b cnt=%0d, want all 0",
               d_out, d_valid, d_busy, d_done, d_cnt);
    end
    tests++;
    if (g2_cnt !== 8'd0 || g0_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_cnts: g2_cnt=%0d g0_cnt=%0d, want 0 0", g2_cnt, g0_cnt);
    end
    #1;
    rst = 1'b1;
    tick();
    tests++;
    if (d_busy !== 1'b0 || d_valid !== 1'b0 || d_out !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_wait: busy=%b valid=%b out=%b, want 0 0 0", d_busy, d_valid, d_out);
    end
    run_full_pattern("rstmid", 8'd1);
  endtask

  task automatic run_burst15(input int idx);
    int n;
    d_rc    = 4'd15;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    n = 0;
    while (d_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (d_done !== 1'b1) begin
      fails++;
      $display("FAIL sat_timeout%0d: done=%b after %0d cycles, want done=1", idx, d_done, n);
    end
    tick();
  endtask

  task automatic test_saturate;
    for (int b = 0; b < 16; b++) run_burst15(b);
    tests++;
    if (d_cnt !== 8'd241) begin
      fails++;
      $display("FAIL sat_pre: cnt=%0d, want 241", d_cnt);
    end
    run_burst15(16);
    tests++;
    if (d_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_hit: cnt=%0d, want 255", d_cnt);
    end
    run_burst15(17);
    tests++;
    if (d_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_hold: cnt=%0d, want 255", d_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    d_start  = 1'b0;
    d_abort  = 1'b0;
    d_rc     = 4'd0;
    g2_start = 1'b0;
    g2_abort = 1'b0;
    g2_rc    = 4'd0;
    g0_start = 1'b0;
    g0_abort = 1'b0;
    g0_rc    = 4'd0;
    test_reset();
    test_single();
    test_zero_repeat();
    test_abort();
    test_gap2();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
